// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: main + skid register behind a valid/ready handshake, with freeze and flush.
// Optional stall/flush statistics counters are built when PIPE_STAGE_SKID_STATS_EN is defined.
module pipe_stage_skid #(
  parameter int                    DATA_WIDTH   = 64,
  parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_pipeline_enable,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic [31:0]           o_stall_cycles,
  output logic [15:0]           o_flush_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_p0, state_d;
  logic [DATA_WIDTH-1:0] m_data_p0, m_data_d;
  logic [DATA_WIDTH-1:0] s_data_p0, s_data_d;
  logic                  accept, emit;

  // Handshake decode depends only on registered state and the run enable.
  assign o_ready = i_pipeline_enable && (state_p0 != FULL);
  assign o_valid = i_pipeline_enable && (state_p0 != EMPTY);
  assign o_data  = m_data_p0;
  assign accept  = i_valid && o_ready;
  assign emit    = o_valid && i_ready;

  always_comb begin
    state_d  = state_p0;
    m_data_d = m_data_p0;
    s_data_d = s_data_p0;
    if (!i_pipeline_enable) begin
      state_d = state_p0;
    end else if (i_flush) begin
      state_d  = EMPTY;
      m_data_d = BUBBLE_VALUE;
      s_data_d = BUBBLE_VALUE;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (accept) begin
            m_data_d = i_data;
            state_d  = BUSY;
          end
        end
        BUSY: begin
          if (accept && emit) begin
            m_data_d = i_data;
          end else if (accept) begin
            s_data_d = i_data;
            state_d  = FULL;
          end else if (emit) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            m_data_d = s_data_p0;
            state_d  = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // ---- stage register (falling edge, like the neighbouring pipeline registers) ----
  always_ff @(negedge i_clock) begin
    if (i_reset) begin
      state_p0  <= EMPTY;
      m_data_p0 <= BUBBLE_VALUE;
      s_data_p0 <= BUBBLE_VALUE;
    end else begin
      state_p0  <= state_d;
      m_data_p0 <= m_data_d;
      s_data_p0 <= s_data_d;
    end
  end

`ifdef PIPE_STAGE_SKID_STATS_EN
  logic [31:0] stall_p0;
  logic [15:0] flush_p0;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---- statistics counters ----
  always_ff @(negedge i_clock) begin
    if (i_reset) begin
      stall_p0 <= 32'd0;
      flush_p0 <= 16'd0;
    end else if (i_pipeline_enable) begin
      if (i_flush) begin
        flush_p0 <= sat_inc16(flush_p0);
      end else if (o_valid && !i_ready) begin
        stall_p0 <= sat_inc32(stall_p0);
      end
    end
  end

  assign o_stall_cycles = stall_p0;
  assign o_flush_count  = flush_p0;
`else
  assign o_stall_cycles = 32'd0;
  assign o_flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a depth-2 FIFO reference model plus directed and random stimulus.
// Honours PIPE_STAGE_SKID_STATS_EN for the expected counter values.
module tb_pipe_stage_skid;
  localparam int          W   = 64;
  localparam logic [W-1:0] BUB = 64'h0000_DEAD_0000_BEEF;

  logic         clk = 1'b0;
  logic         i_reset = 1'b0, i_pipeline_enable = 1'b0, i_flush = 1'b0;
  logic         i_valid = 1'b0, i_ready = 1'b0;
  logic [W-1:0] i_data = '0;
  logic         o_ready, o_valid;
  logic [W-1:0] o_data;
  logic [31:0]  o_stall_cycles;
  logic [15:0]  o_flush_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb[$];
  bit           known = 1'b0;
  bit           bubble_exp = 1'b0;
  int unsigned  stall_exp = 0;
  int unsigned  flush_exp = 0;

  pipe_stage_skid #(.DATA_WIDTH(W), .BUBBLE_VALUE(BUB)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_pipeline_enable(i_pipeline_enable),
    .i_flush(i_flush), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .o_stall_cycles(o_stall_cycles), .o_flush_count(o_flush_count)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs after the rising edge, check outputs, advance the model for the falling edge.
  task automatic step(input bit rst, input bit en, input bit fl, input bit vl,
                      input logic [W-1:0] d, input bit rdy);
    bit mready, mvalid;
    @(posedge clk);
    #1;
    i_reset = rst; i_pipeline_enable = en; i_flush = fl;
    i_valid = vl; i_data = d; i_ready = rdy;
    #1;
    mready = en && (sb.size() < 2);
    mvalid = en && (sb.size() > 0);
    if (known) begin
      chk("o_ready", {63'd0, o_ready}, {63'd0, mready});
      chk("o_valid", {63'd0, o_valid}, {63'd0, mvalid});
      if (sb.size() > 0) chk("o_data_head", o_data, sb[0]);
      else if (bubble_exp) chk("o_data_bubble", o_data, BUB);
`ifdef PIPE_STAGE_SKID_STATS_EN
      chk("stall_cycles", {32'd0, o_stall_cycles}, {32'd0, stall_exp});
      chk("flush_count", {48'd0, o_flush_count}, {32'd0, flush_exp});
`else
      chk("stall_cycles", {32'd0, o_stall_cycles}, 64'd0);
      chk("flush_count", {48'd0, o_flush_count}, 64'd0);
`endif
    end
    if (rst) begin
      sb.delete();
      stall_exp = 0; flush_exp = 0; bubble_exp = 1'b1; known = 1'b1;
    end else if (!en) begin
      // frozen: nothing changes
    end else if (fl) begin
      sb.delete();
      flush_exp++; bubble_exp = 1'b1;
    end else begin
      if (mvalid && !rdy) stall_exp++;
      if (vl && mready) begin
        sb.push_back(d);
        bubble_exp = 1'b0;
      end
    end
  endtask

  // Monitor: every completed emit must deliver the oldest outstanding payload.
  initial forever begin
    @(posedge clk);
    #3;
    if (known && !i_reset && i_pipeline_enable && !i_flush && i_ready && o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL emit_spurious actual=%0h required=no_emit", o_data);
      end else begin
        chk("emit_data", o_data, sb.pop_front());
      end
    end
  end

  initial begin
    step(1, 1, 0, 0, '0, 1);
    step(1, 1, 0, 0, '0, 1);
    // Streaming at full throughput
    step(0, 1, 0, 1, 64'h11, 1);
    step(0, 1, 0, 1, 64'h22, 1);
    step(0, 1, 0, 1, 64'h33, 1);
    step(0, 1, 0, 0, '0, 1);
    step(0, 1, 0, 0, '0, 1);
    // Backpressure fills the skid register, then drains in order
    step(0, 1, 0, 1, 64'hA, 0);
    step(0, 1, 0, 1, 64'hB, 0);
    step(0, 1, 0, 1, 64'hE, 0);
    step(0, 1, 0, 0, '0, 1);
    step(0, 1, 0, 0, '0, 1);
    step(0, 1, 0, 0, '0, 1);
    // Flush while full with an incoming payload
    step(0, 1, 0, 1, 64'hA, 0);
    step(0, 1, 0, 1, 64'hB, 0);
    step(0, 1, 1, 1, 64'hC, 0);
    step(0, 1, 0, 0, '0, 1);
    step(0, 1, 0, 0, '0, 1);
    // Freeze with flush and valid pulses has no effect
    step(0, 1, 0, 1, 64'h5, 0);
    step(0, 0, 1, 1, 64'h6, 1);
    step(0, 0, 0, 1, 64'h7, 1);
    step(0, 0, 1, 1, 64'h8, 1);
    step(0, 1, 0, 0, '0, 0);
    step(0, 1, 0, 0, '0, 1);
    // Reset while full
    step(0, 1, 0, 1, 64'h91, 0);
    step(0, 1, 0, 1, 64'h92, 0);
    step(1, 1, 0, 0, '0, 0);
    step(0, 1, 0, 0, '0, 0);
    // Ten stalled edges
    step(0, 1, 0, 1, 64'h77, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, '0, 0);
    step(0, 1, 0, 0, '0, 1);
`ifdef PIPE_STAGE_SKID_STATS_EN
    chk("stall_10", {32'd0, o_stall_cycles}, 64'd10);
`else
    chk("stall_10", {32'd0, o_stall_cycles}, 64'd0);
`endif
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1),
           {$urandom, $urandom}, ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, '0, 1);
    @(posedge clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, elastic pipeline stage register: the successor to the fixed-width stall/flush stage registers between pipeline stages. It carries a DATA_WIDTH payload with a valid/ready handshake on both sides and a two-entry skid buffer, so backpressure no longer has to reach upstream in the same cycle. It keeps the debug-unit freeze (`i_pipeline_enable`) and the hazard flush that insert a bubble. It is dropped between any two stages (IF/ID, ID/EX, …) by setting DATA_WIDTH and BUBBLE_VALUE.

## Interface
- DATA_WIDTH, 64: payload width in bits (e.g. PC + instruction).
- BUBBLE_VALUE, {DATA_WIDTH{1'b0}}: payload value loaded on reset and on flush (a NOP).
- i_clock  in  1  single clock; all state updates on the falling edge, as for the other pipeline registers.
- i_reset  in  1  synchronous, active-high reset, sampled on the falling edge of i_clock.
- i_pipeline_enable  in  1  debug-unit run enable; 0 freezes the stage.
- i_flush  in  1  control-hazard flush; discards all held and incoming data.
- i_valid  in  1  upstream payload valid.
- i_data  in  DATA_WIDTH  upstream payload.
- o_ready  out  1  stage can accept; = i_pipeline_enable && state != FULL.
- o_valid  out  1  payload available; = i_pipeline_enable && state != EMPTY.
- o_data  out  DATA_WIDTH  main-register payload; driven whether or not o_valid is high.
- i_ready  in  1  downstream accepts.
- o_stall_cycles  out  32  stall counter (see Configuration).
- o_flush_count  out  16  flush counter (see Configuration).

## Operation
- Storage: main register M (drives o_data), skid register S, and a 2-bit state: EMPTY, BUSY (M full), FULL (M and S full).
- Handshakes, evaluated at the falling edge with i_pipeline_enable=1: accept = i_valid && o_ready; emit = o_valid && i_ready.
- Priority, highest first: i_reset, then !i_pipeline_enable, then i_flush, then normal transitions.
- Reset: state=EMPTY; M=S=BUBBLE_VALUE; counters=0.
- Freeze (i_pipeline_enable=0): state, M, S and counters hold. o_valid=o_ready=0, so no handshake completes. i_flush is ignored.
- Flush: state=EMPTY; M=S=BUBBLE_VALUE. An incoming accept on the same edge is dropped, and so is any emit. The flush counter increments.
- EMPTY: accept → M=i_data, BUSY; otherwise stay EMPTY.
- BUSY, accept && emit → M=i_data, stay BUSY.
- BUSY, accept && !emit → S=i_data, FULL.
- BUSY, !accept && emit → EMPTY; M holds its stale value.
- BUSY, neither → hold.
- FULL, emit → M=S, BUSY; no accept is possible because o_ready=0.
- FULL, no emit → hold.
- Ordering is strictly FIFO. No payload is duplicated or lost except by flush or reset.

## Timing
- Latency: an accept at falling edge n makes o_valid=1 with that payload after edge n (visible for the cycle following n).
- Throughput: one transfer per cycle while i_ready=1.
- o_ready and o_valid are decoded from registered state, gated only by i_pipeline_enable. There is no combinational path from i_ready to o_ready.
- Reset mid-operation: all held data is discarded at that edge, and outputs show reset values from the next cycle.
- Reset values: o_valid=0, o_ready=i_pipeline_enable, o_data=BUBBLE_VALUE, counters=0.

## Configuration
- Macro: PIPE_STAGE_SKID_STATS_EN.
- Defined:
  - o_stall_cycles increments on each enabled, non-flush edge where o_valid && !i_ready.
  - o_flush_count increments on each enabled flush edge.
  - Both counters saturate at all-ones and clear only on reset.
- Undefined: no counter logic is built. The ports remain and are tied to 0.

## Test plan
- Reset, then stream 0x11, 0x22, 0x33 with i_ready=1 → o_data presents 0x11, 0x22, 0x33 on consecutive cycles, each one edge after its accept; o_ready stays 1.
- Load 0xA, then hold i_ready=0 and offer 0xB → FULL and o_ready=0. Raise i_ready → 0xA then 0xB are emitted in order, and o_ready returns to 1 after the first emit.
- FULL with 0xA/0xB, assert i_flush with i_valid=1 and i_data=0xC → EMPTY, o_valid=0, o_data=BUBBLE_VALUE; 0xC is not delivered; o_flush_count=1 (macro on).
- BUSY with 0x5, drop i_pipeline_enable for 3 cycles while pulsing i_flush and i_valid → o_valid=o_ready=0 throughout. After re-enable, o_data=0x5, o_valid=1 and the flush has had no effect.
- Assert i_reset while FULL → next cycle o_valid=0, o_data=BUBBLE_VALUE and counters 0.
- Macro on: hold a valid payload with i_ready=0 for 10 enabled edges → o_stall_cycles=10. Macro off → o_stall_cycles=0.
